bird_motion: RTL and testbench

- Parametrised bird kinematics engine for the Flappy Bird datapath.
- Integrates signed velocity under configurable gravity on a 1 ms tick enable.
- Applies a flap impulse on each rising edge of the button, clamps at the ceiling and detects ground impact.
- Tracks a four-state life cycle: idle, flying, dying after a pipe hit, dead.
- Feeds the renderer (y_pos, tilt) and the game controller (dead).

---
 rtl/bird_pkg.sv | 42 ++++
 rtl/bird_integrator.sv | 59 +++++
 rtl/bird_motion.sv | 173 +++++++++++++++++
 tb/tb_bird_motion.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bird_pkg.sv
// Shared definitions for the bird kinematics engine: FSM encoding, game-state
// codes, screen geometry and the tilt lookup used when BIRD_TILT_EN is defined.
package bird_pkg;

  // Bird life-cycle states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLY   = 2'd1,
    S_DYING = 2'd2,
    S_DEAD  = 2'd3
  } bird_state_e;

  // Game controller state codes; codes 2 and 3 both mean "game over / freeze"
  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;

  // Screen geometry shared with the pipe and VGA blocks (y up-positive)
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int GROUND_Y = 0;

  // Sprite angle used whenever the bird is level or tilting is disabled
  localparam logic [2:0] TILT_LEVEL = 3'd3;

  // Both "over" codes share the top bit, so one bit decides the freeze
  function automatic logic is_freeze(input logic [1:0] st);
    return st[1];
  endfunction

  // Velocity (pixels/tick, positive = up) to sprite angle index
  function automatic logic [2:0] tilt_of(input int v);
    if (v >= 12)       return 3'd0;
    else if (v >= 6)   return 3'd1;
    else if (v >= 1)   return 3'd2;
    else if (v == 0)   return 3'd3;
    else if (v >= -5)  return 3'd4;
    else if (v >= -11) return 3'd5;
    else if (v >= -23) return 3'd6;
    else               return 3'd7;
  endfunction

endpackage

// File: rtl/bird_integrator.sv
// Combinational one-tick physics step: saturating velocity update (or flap
// impulse), signed position add and ceiling/ground clamp.
module bird_integrator
  import bird_pkg::*;
#(
  parameter int POS_W    = 9,
  parameter int VEL_W    = 6,
  parameter int Y_MAX    = 479,
  parameter int FLAP_VEL = 20,
  parameter int GRAVITY  = 1,
  parameter int VMAX     = 31
) (
  input  logic        [POS_W-1:0] pos_i,
  input  logic signed [VEL_W-1:0] vel_i,
  input  logic                    flap_i,
  output logic        [POS_W-1:0] pos_o,
  output logic signed [VEL_W-1:0] vel_o,
  output logic                    ground_o
);

  // One extra velocity bit so the gravity subtraction cannot wrap before the clamp
  localparam logic signed [VEL_W:0]   GRAV_W = (VEL_W+1)'(GRAVITY);
  localparam logic signed [VEL_W:0]   VMIN_W = (VEL_W+1)'(-VMAX);
  localparam logic signed [VEL_W-1:0] FLAP_W = VEL_W'(FLAP_VEL);
  // Two extra position bits hold both the overshoot above Y_MAX and negatives
  localparam logic signed [POS_W+1:0] YMAX_W = (POS_W+2)'(Y_MAX);
  localparam logic signed [POS_W+1:0] ZERO_W = '0;

  logic signed [VEL_W:0]   vel_dec;
  logic signed [VEL_W-1:0] vel_grav;
  logic signed [VEL_W-1:0] vel_new;
  logic signed [POS_W+1:0] pos_ext;
  logic signed [POS_W+1:0] vel_ext;
  logic signed [POS_W+1:0] y_sum;

  // Velocity update, then position add, then clamp against ceiling and ground
  always_comb begin
    vel_dec  = {vel_i[VEL_W-1], vel_i} - GRAV_W;
    vel_grav = (vel_dec < VMIN_W) ? VMIN_W[VEL_W-1:0] : vel_dec[VEL_W-1:0];
    vel_new  = flap_i ? FLAP_W : vel_grav;

    pos_ext  = {2'b00, pos_i};
    vel_ext  = {{(POS_W+2-VEL_W){vel_new[VEL_W-1]}}, vel_new};
    y_sum    = pos_ext + vel_ext;

    pos_o    = y_sum[POS_W-1:0];
    vel_o    = vel_new;
    ground_o = 1'b0;
    if (y_sum >= YMAX_W) begin
      pos_o = YMAX_W[POS_W-1:0];
      vel_o = '0;
    end else if (y_sum <= ZERO_W) begin
      pos_o    = '0;
      vel_o    = '0;
      ground_o = 1'b1;
    end
  end

endmodule

// File: rtl/bird_motion.sv
// Bird kinematics engine: flap edge capture, life-cycle FSM and registered
// position/velocity/tilt outputs. Physics advances only on tick.
// Optional feature macro BIRD_TILT_EN: when defined, tilt follows velocity
// (forced fully nose-down while dying); otherwise tilt is tied level.
module bird_motion
  import bird_pkg::*;
#(
  parameter int POS_W    = 9,
  parameter int VEL_W    = 6,
  parameter int Y_INIT   = 240,
  parameter int Y_MAX    = 479,
  parameter int FLAP_VEL = 20,
  parameter int GRAVITY  = 1,
  parameter int VMAX     = 31
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    up_button,
  input  logic [1:0]              state,
  input  logic                    pipe_hit,
  output logic [POS_W-1:0]        V_pos,
  output logic signed [VEL_W-1:0] velocity,
  output logic [2:0]              tilt,
  output logic                    isDead
);

  localparam logic [POS_W-1:0] Y_INIT_W = POS_W'(Y_INIT);

  bird_state_e             fsm_q, fsm_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic                    flap_pend_q, flap_pend_d;
  logic                    dead_q, dead_d;
  logic                    btn_q;

  logic                    btn_rise;
  logic                    freeze;
  logic                    consume;
  logic                    integ_flap;
  logic [POS_W-1:0]        integ_pos;
  logic signed [VEL_W-1:0] integ_vel;
  logic                    integ_ground;

  assign btn_rise   = up_button & ~btn_q;
  assign freeze     = is_freeze(state);
  // A flap only counts while flying and is discarded on the tick of a pipe hit
  assign integ_flap = (fsm_q == S_FLY) && flap_pend_q && !pipe_hit;

  bird_integrator #(
    .POS_W    (POS_W),
    .VEL_W    (VEL_W),
    .Y_MAX    (Y_MAX),
    .FLAP_VEL (FLAP_VEL),
    .GRAVITY  (GRAVITY),
    .VMAX     (VMAX)
  ) u_integrator (
    .pos_i    (pos_q),
    .vel_i    (vel_q),
    .flap_i   (integ_flap),
    .pos_o    (integ_pos),
    .vel_o    (integ_vel),
    .ground_o (integ_ground)
  );

  // Next-state and physics decode; a state change on a clk takes priority over tick
  always_comb begin
    fsm_d   = fsm_q;
    pos_d   = pos_q;
    vel_d   = vel_q;
    consume = 1'b0;
    unique case (fsm_q)
      S_IDLE: begin
        pos_d = Y_INIT_W;
        vel_d = '0;
        if (state == ST_PLAY) fsm_d = S_FLY;
      end
      S_FLY: begin
        if (state == ST_READY) begin
          fsm_d = S_IDLE;
          pos_d = Y_INIT_W;
          vel_d = '0;
        end else if (!freeze && tick) begin
          consume = 1'b1;
          if (pipe_hit) begin
            // Hit stops the bird in place unless this tick also lands it
            vel_d = '0;
            if (integ_ground) begin
              pos_d = '0;
              fsm_d = S_DEAD;
            end else begin
              fsm_d = S_DYING;
            end
          end else begin
            pos_d = integ_pos;
            vel_d = integ_vel;
            if (integ_ground) fsm_d = S_DEAD;
          end
        end
      end
      S_DYING: begin
        if (state == ST_READY) begin
          fsm_d = S_IDLE;
          pos_d = Y_INIT_W;
          vel_d = '0;
        end else if (!freeze && tick) begin
          pos_d = integ_pos;
          vel_d = integ_vel;
          if (integ_ground) fsm_d = S_DEAD;
        end
      end
      S_DEAD: begin
        if (state == ST_READY) begin
          fsm_d = S_IDLE;
          pos_d = Y_INIT_W;
          vel_d = '0;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // Flap bookkeeping: a pending flap survives until a physics tick uses it
  always_comb begin
    if (fsm_q != S_FLY) flap_pend_d = 1'b0;
    else                flap_pend_d = (flap_pend_q & ~consume) | btn_rise;
    dead_d = (fsm_q == S_DEAD) && (fsm_d == S_DEAD);
  end

  // State, physics and edge-capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= S_IDLE;
      pos_q       <= Y_INIT_W;
      vel_q       <= '0;
      flap_pend_q <= 1'b0;
      dead_q      <= 1'b0;
      btn_q       <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      pos_q       <= pos_d;
      vel_q       <= vel_d;
      flap_pend_q <= flap_pend_d;
      dead_q      <= dead_d;
      btn_q       <= up_button;
    end
  end

`ifdef BIRD_TILT_EN
  logic [2:0] tilt_q, tilt_d;

  // Sprite angle tracks the velocity being loaded; dying is always nose-down
  always_comb begin
    tilt_d = tilt_of(int'(vel_d));
    if (fsm_d == S_DYING) tilt_d = 3'd7;
  end

  // Tilt register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tilt_q <= TILT_LEVEL;
    else        tilt_q <= tilt_d;
  end

  assign tilt = tilt_q;
`else
  assign tilt = TILT_LEVEL;
`endif

  assign V_pos    = pos_q;
  assign velocity = vel_q;
  assign isDead   = dead_q;

endmodule

// File: tb/tb_bird_motion.sv
// Directed bench for bird_motion with a reference model feeding a scoreboard.
// Honours BIRD_TILT_EN for the expected tilt values.
module tb_bird_motion;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tick = 1'b0;
  logic              up_button = 1'b0;
  logic              pipe_hit = 1'b0;
  logic [1:0]        state = 2'd0;
  logic [8:0]        V_pos;
  logic signed [5:0] velocity;
  logic [2:0]        tilt;
  logic              isDead;

  // Second instance with a small VMAX so saturation is reachable before ground
  logic              s_btn = 1'b0;
  logic [8:0]        s_pos;
  logic signed [5:0] s_vel;
  logic [2:0]        s_tilt;
  logic              s_dead;

  always #5 clk = ~clk;

  bird_motion dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .up_button(up_button),
    .state(state), .pipe_hit(pipe_hit),
    .V_pos(V_pos), .velocity(velocity), .tilt(tilt), .isDead(isDead)
  );

  bird_motion #(.VMAX(6), .FLAP_VEL(6)) dut_sat (
    .clk(clk), .rst_n(rst_n), .tick(tick), .up_button(s_btn),
    .state(state), .pipe_hit(pipe_hit),
    .V_pos(s_pos), .velocity(s_vel), .tilt(s_tilt), .isDead(s_dead)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_pos, m_vel;
  bit m_dying, m_dead;

  typedef struct {
    string tag;
    int    pos;
    int    vel;
    int    tlt;
    int    dead;
  } exp_t;
  exp_t sb[$];

  function automatic int exp_tilt(input int v, input bit dying);
    int t;
    if (dying)         t = 7;
    else if (v >= 12)  t = 0;
    else if (v >= 6)   t = 1;
    else if (v >= 1)   t = 2;
    else if (v == 0)   t = 3;
    else if (v >= -5)  t = 4;
    else if (v >= -11) t = 5;
    else if (v >= -23) t = 6;
    else               t = 7;
`ifndef BIRD_TILT_EN
    t = 3;
`endif
    return t;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pos = 240; m_vel = 0; m_dying = 0; m_dead = 0;
  endtask

  // One physics tick of the reference model
  task automatic model_tick(input bit flap, input bit hit);
    int v, y;
    if (m_dead) return;
    v = (flap && !hit && !m_dying) ? 20 : m_vel - 1;
    if (v < -31) v = -31;
    y = m_pos + v;
    if (hit && !m_dying) begin
      if (y <= 0) begin
        m_pos = 0; m_vel = 0; m_dead = 1;
      end else begin
        m_vel = 0; m_dying = 1;
      end
    end else if (y >= 479) begin
      m_pos = 479; m_vel = 0;
    end else if (y <= 0) begin
      m_pos = 0; m_vel = 0; m_dead = 1; m_dying = 0;
    end else begin
      m_pos = y; m_vel = v;
    end
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, "_pos"},  int'(V_pos), e.pos);
    chk({e.tag, "_vel"},  int'(velocity), e.vel);
    chk({e.tag, "_tilt"}, int'(tilt), e.tlt);
    chk({e.tag, "_dead"}, int'(isDead), e.dead);
    $display("tick %-10s V_pos=%0d velocity=%0d tilt=%0d isDead=%0d",
             e.tag, V_pos, velocity, tilt, isDead);
  endtask

  task automatic do_tick(input string tag, input bit flap, input bit hit);
    exp_t e;
    bit   was_dead;
    was_dead = m_dead;
    model_tick(flap, hit);
    e.tag  = tag;
    e.pos  = m_pos;
    e.vel  = m_vel;
    e.tlt  = exp_tilt(m_vel, m_dying);
    e.dead = (was_dead && m_dead) ? 1 : 0;
    sb.push_back(e);
    tick = 1'b1; pipe_hit = hit;
    step();
    tick = 1'b0; pipe_hit = 1'b0;
    check_out();
  endtask

  task automatic rise();
    up_button = 1'b1; step();
    up_button = 1'b0; step();
  endtask

  initial begin
    int sv, sp;

    // Reset state
    step(); step();
    chk("rst_pos",  int'(V_pos), 240);
    chk("rst_vel",  int'(velocity), 0);
    chk("rst_tilt", int'(tilt), 3);
    chk("rst_dead", int'(isDead), 0);
    rst_n = 1'b1;
    step();
    state = 2'd1;
    step();
    model_reset();

    // Free fall for 10 ticks; the small-VMAX instance saturates at -6
    sv = 0; sp = 240;
    for (int k = 1; k <= 10; k++) begin
      do_tick("fall", 1'b0, 1'b0);
      sv = (sv - 1 < -6) ? -6 : sv - 1;
      sp = sp + sv;
      chk("sat_vel", int'(s_vel), sv);
    end
    chk("fall10_pos", int'(V_pos), 185);
    chk("fall10_vel", int'(velocity), -10);
    chk("sat_pos",    int'(s_pos), 195);
    chk("sat_pos_m",  int'(s_pos), sp);
    chk("sat_tilt",   int'(s_tilt), exp_tilt(-6, 1'b0));
    chk("sat_dead",   int'(s_dead), 0);

    // Asynchronous reset mid-flight, checked before any clk edge
    #3 rst_n = 1'b0;
    #1;
    chk("areset_pos",  int'(V_pos), 240);
    chk("areset_vel",  int'(velocity), 0);
    chk("areset_tilt", int'(tilt), 3);
    chk("areset_dead", int'(isDead), 0);
    step();
    rst_n = 1'b1;
    step();
    model_reset();

    // Flap from velocity -5, held button, and double rise before one tick
    repeat (5) do_tick("fall5", 1'b0, 1'b0);
    chk("fall5_vel", int'(velocity), -5);
    up_button = 1'b1;
    step(); step(); step();
    do_tick("flap", 1'b1, 1'b0);
    chk("flap_vel", int'(velocity), 20);
    do_tick("held", 1'b0, 1'b0);
    chk("held_vel", int'(velocity), 19);
    up_button = 1'b0;
    step();
    rise(); rise();
    do_tick("two_rise", 1'b1, 1'b0);
    do_tick("one_flap", 1'b0, 1'b0);

    // Repeated flaps into the ceiling
    for (int k = 0; k < 15 && m_pos < 479; k++) begin
      rise();
      do_tick("ceil", 1'b1, 1'b0);
      chk("ceil_bound", (V_pos > 9'd479) ? 1 : 0, 0);
    end
    chk("ceil_pos", int'(V_pos), 479);
    chk("ceil_vel", int'(velocity), 0);

    // Pipe hit with a pending flap, then ignored flaps while dying
    rise();
    do_tick("hit", 1'b1, 1'b1);
    for (int k = 0; k < 60 && !m_dead; k++) begin
      if (k % 4 == 0) rise();
      do_tick("dying", (k % 4 == 0), 1'b0);
    end
    step();
    chk("dead_late", int'(isDead), 1);
    chk("dead_pos",  int'(V_pos), 0);
    do_tick("dead_hold", 1'b0, 1'b0);

    // Back to idle
    state = 2'd0;
    step();
    chk("idle_pos",  int'(V_pos), 240);
    chk("idle_vel",  int'(velocity), 0);
    chk("idle_dead", int'(isDead), 0);
    model_reset();

    // Tick coinciding with the state change does no physics
    state = 2'd1; tick = 1'b1;
    step();
    tick = 1'b0;
    chk("enter_pos", int'(V_pos), 240);
    chk("enter_vel", int'(velocity), 0);
    repeat (3) do_tick("fly", 1'b0, 1'b0);

    // Freeze: tick while game over holds position and velocity
    state = 2'd2; tick = 1'b1;
    step();
    tick = 1'b0;
    chk("frz_pos", int'(V_pos), m_pos);
    chk("frz_vel", int'(velocity), m_vel);
    state = 2'd3; rise();
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("frz3_pos", int'(V_pos), m_pos);
    state = 2'd1;
    step();
    do_tick("resume", 1'b1, 1'b0);

    // Hit on the same tick as ground contact goes straight to dead
    for (int k = 0; k < 60 && (m_pos + m_vel - 1 > 0); k++)
      do_tick("dive", 1'b0, 1'b0);
    do_tick("hit_ground", 1'b0, 1'b1);
    step();
    chk("hg_dead", int'(isDead), 1);
    chk("hg_pos",  int'(V_pos), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
